// File: rtl/rbus_pkg.sv
// Shared d2r ring types: control word, frame header layout and frame-length helpers.
package rbus_pkg;

  localparam int unsigned PAYLOAD_SHORT = 1;
  localparam int unsigned PAYLOAD_LONG  = 8;
  localparam int unsigned FRM_WORDS     = PAYLOAD_LONG + 1;

  typedef struct packed {
    logic       valid;
    logic [2:0] tag;
    logic [3:0] chan;
  } rbus_ctrl_t;

  typedef struct packed {
    logic        frm_used;
    logic        frm_len;
    logic [5:0]  dst;
    logic [7:0]  src;
    logic [47:0] info;
  } rbus_hdr_t;

  typedef union packed {
    logic [63:0] raw;
    rbus_hdr_t   header;
  } rbus_word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARMED,
    ST_SEND
  } inj_state_t;

  // Number of payload words that follow a header with the given frm_len.
  function automatic logic [3:0] payload_len(input logic frm_len);
    return frm_len ? 4'(PAYLOAD_LONG) : 4'(PAYLOAD_SHORT);
  endfunction

endpackage

// File: rtl/rsbus_frm_buf.sv
// Single-frame buffer: header at index 0, payload at 1..N, with write/read indices and full flag.
module rsbus_frm_buf
  import rbus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hdr_we,
  input  logic       pay_we,
  input  rbus_word_t wr_data,
  input  logic       rd_start,
  input  logic       rd_inc,
  input  logic       clr_full,
  output rbus_word_t hdr,
  output rbus_word_t rd_data,
  output logic       wr_last,
  output logic       rd_last,
  output logic       full
);

  rbus_word_t mem [FRM_WORDS];
  logic [3:0] wr_idx;
  logic [3:0] rd_idx;
  logic [3:0] n;

  assign hdr     = mem[0];
  assign n       = payload_len(mem[0].header.frm_len);
  assign rd_data = mem[rd_idx];
  assign wr_last = (wr_idx == n);
  assign rd_last = (rd_idx == n);

  // NOTE: the storage array is deliberately left without reset; the full flag
  // and the FSM guarantee no word is read before it has been written.
  always_ff @(posedge clk) begin
    if (hdr_we)
      mem[0] <= wr_data;
    else if (pay_we)
      mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx <= 4'd1;
      rd_idx <= 4'd1;
      full   <= 1'b0;
    end else begin
      if (hdr_we) begin
        wr_idx <= 4'd1;
        full   <= 1'b0;
      end else if (pay_we) begin
        if (wr_last)
          full <= 1'b1;
        else
          wr_idx <= wr_idx + 4'd1;
      end else if (clr_full) begin
        full <= 1'b0;
      end

      if (rd_start)
        rd_idx <= 4'd1;
      else if (rd_inc && !rd_last)
        rd_idx <= rd_idx + 4'd1;
    end
  end

endmodule

// File: rtl/rsbus_d2r_inject.sv
// d2r ring inserter: buffers one device frame and overwrites the next empty slot of matching length.
module rsbus_d2r_inject
  import rbus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       d2r_i_sof,
  input  rbus_ctrl_t d2r_i_ctrl,
  input  rbus_word_t d2r_i_bus,
  output logic       d2r_o_sof,
  output rbus_ctrl_t d2r_o_ctrl,
  output rbus_word_t d2r_o_bus,
  input  logic       dev_i_stb,
  input  logic       dev_i_sof,
  input  rbus_word_t dev_i_bus,
  output logic       dev_o_rdy,
  output logic       pkt_sent,
  output logic       inj_err,
  output logic [7:0] starve_cnt
);

  inj_state_t state;

  logic       hdr_we;
  logic       pay_we;
  logic       rd_start;
  logic       rd_inc;
  logic       clr_full;
  logic       wr_last;
  logic       rd_last;
  logic       full;
  logic       slot_match;
  rbus_word_t buf_hdr;
  rbus_word_t rd_data;
  rbus_word_t inject_hdr;

  rsbus_frm_buf u_frm_buf (
    .clk      (clk),
    .rst      (rst),
    .hdr_we   (hdr_we),
    .pay_we   (pay_we),
    .wr_data  (dev_i_bus),
    .rd_start (rd_start),
    .rd_inc   (rd_inc),
    .clr_full (clr_full),
    .hdr      (buf_hdr),
    .rd_data  (rd_data),
    .wr_last  (wr_last),
    .rd_last  (rd_last),
    .full     (full)
  );

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    inject_hdr                 = buf_hdr;
    inject_hdr.header.frm_used = 1'b1;
    hdr_we     = dev_i_stb && dev_i_sof && (state == ST_IDLE || state == ST_LOAD);
    pay_we     = dev_i_stb && !dev_i_sof && (state == ST_LOAD);
    slot_match = d2r_i_sof && full && !d2r_i_bus.header.frm_used &&
                 (d2r_i_bus.header.frm_len == buf_hdr.header.frm_len);
    // An early sof in SEND is judged exactly as if the block were ARMED.
    rd_start   = slot_match && (state == ST_ARMED || state == ST_SEND);
    rd_inc     = (state == ST_SEND) && !d2r_i_sof;
    clr_full   = rd_inc && rd_last;
  end

  // NOTE: sequential state uses non-blocking assignments only, so later
  // overrides in the same cycle (e.g. ctrl.valid) read as plain priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      d2r_o_sof  <= 1'b0;
      d2r_o_ctrl <= '0;
      d2r_o_bus  <= '0;
      dev_o_rdy  <= 1'b1;
      pkt_sent   <= 1'b0;
      inj_err    <= 1'b0;
      starve_cnt <= 8'd0;
    end else begin
      d2r_o_sof  <= d2r_i_sof;
      d2r_o_ctrl <= d2r_i_ctrl;
      d2r_o_bus  <= d2r_i_bus;
      pkt_sent   <= 1'b0;
      inj_err    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (hdr_we)
            state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (pay_we && wr_last) begin
            state     <= ST_ARMED;
            dev_o_rdy <= 1'b0;
          end
        end
        ST_ARMED, ST_SEND: begin
          if (d2r_i_sof) begin
            if (state == ST_SEND)
              inj_err <= 1'b1;
            if (slot_match) begin
              d2r_o_bus        <= inject_hdr;
              d2r_o_ctrl.valid <= 1'b1;
              starve_cnt       <= 8'd0;
              state            <= ST_SEND;
            end else begin
              if (starve_cnt != 8'hFF)
                starve_cnt <= starve_cnt + 8'd1;
              state <= ST_ARMED;
            end
          end else if (state == ST_SEND) begin
            d2r_o_bus <= rd_data;
            if (rd_last) begin
              pkt_sent  <= 1'b1;
              dev_o_rdy <= 1'b1;
              state     <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsbus_d2r_inject.sv
// Directed bench for rsbus_d2r_inject: vector table for the short frame plus hand-written corner sequences.
module tb_rsbus_d2r_inject;
  import rbus_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       d2r_i_sof;
  rbus_ctrl_t d2r_i_ctrl;
  rbus_word_t d2r_i_bus;
  logic       d2r_o_sof;
  rbus_ctrl_t d2r_o_ctrl;
  rbus_word_t d2r_o_bus;
  logic       dev_i_stb;
  logic       dev_i_sof;
  rbus_word_t dev_i_bus;
  logic       dev_o_rdy;
  logic       pkt_sent;
  logic       inj_err;
  logic [7:0] starve_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       sof;
    rbus_ctrl_t ctrl;
    rbus_word_t bus;
    logic       rdy;
    logic       pkt;
    logic       err;
    logic [7:0] starve;
  } obs_t;

  typedef struct packed {
    logic       r_sof;
    rbus_ctrl_t r_ctrl;
    rbus_word_t r_bus;
    logic       d_stb;
    logic       d_sof;
    rbus_word_t d_bus;
  } stim_t;

  typedef struct packed {
    stim_t in;
    obs_t  exp;
  } vec_t;

  rsbus_d2r_inject dut (
    .clk        (clk),
    .rst        (rst),
    .d2r_i_sof  (d2r_i_sof),
    .d2r_i_ctrl (d2r_i_ctrl),
    .d2r_i_bus  (d2r_i_bus),
    .d2r_o_sof  (d2r_o_sof),
    .d2r_o_ctrl (d2r_o_ctrl),
    .d2r_o_bus  (d2r_o_bus),
    .dev_i_stb  (dev_i_stb),
    .dev_i_sof  (dev_i_sof),
    .dev_i_bus  (dev_i_bus),
    .dev_o_rdy  (dev_o_rdy),
    .pkt_sent   (pkt_sent),
    .inj_err    (inj_err),
    .starve_cnt (starve_cnt)
  );

  always #5 clk = ~clk;

  function automatic rbus_word_t hdr(input logic used, input logic len, input logic [7:0] src);
    rbus_word_t w;
    w.raw             = '0;
    w.header.frm_used = used;
    w.header.frm_len  = len;
    w.header.src      = src;
    w.header.info     = {40'h0, src ^ 8'h5A};
    return w;
  endfunction

  function automatic rbus_ctrl_t ctl(input logic v, input logic [2:0] tag, input logic [3:0] chan);
    rbus_ctrl_t c;
    c.valid = v;
    c.tag   = tag;
    c.chan  = chan;
    return c;
  endfunction

  function automatic rbus_word_t pw(input logic [7:0] src, input int i);
    rbus_word_t w;
    w.raw = (64'(src) << 8) | 64'(i);
    return w;
  endfunction

  function automatic stim_t ring(input logic sof, input rbus_ctrl_t c, input rbus_word_t b);
    stim_t s;
    s        = '0;
    s.r_sof  = sof;
    s.r_ctrl = c;
    s.r_bus  = b;
    return s;
  endfunction

  function automatic stim_t dev(input logic sof, input rbus_word_t b);
    stim_t s;
    s       = '0;
    s.d_stb = 1'b1;
    s.d_sof = sof;
    s.d_bus = b;
    return s;
  endfunction

  function automatic obs_t ob(input logic sof, input rbus_ctrl_t c, input rbus_word_t b,
                              input logic rdy, input logic pkt, input logic err, input logic [7:0] st);
    obs_t o;
    o.sof    = sof;
    o.ctrl   = c;
    o.bus    = b;
    o.rdy    = rdy;
    o.pkt    = pkt;
    o.err    = err;
    o.starve = st;
    return o;
  endfunction

  function automatic obs_t observe();
    return ob(d2r_o_sof, d2r_o_ctrl, d2r_o_bus, dev_o_rdy, pkt_sent, inj_err, starve_cnt);
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("sof=%b ctrl=%h bus=%h rdy=%b pkt=%b err=%b starve=%0d",
                     o.sof, o.ctrl, o.bus.raw, o.rdy, o.pkt, o.err, o.starve);
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = observe();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %s want %s", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic step(input stim_t s);
    d2r_i_sof  = s.r_sof;
    d2r_i_ctrl = s.r_ctrl;
    d2r_i_bus  = s.r_bus;
    dev_i_stb  = s.d_stb;
    dev_i_sof  = s.d_sof;
    dev_i_bus  = s.d_bus;
    @(posedge clk);
    #1;
  endtask

  task automatic load_long(input logic [7:0] src);
    step(dev(1'b1, hdr(1'b0, 1'b1, src)));
    for (int i = 1; i <= 8; i++)
      step(dev(1'b0, pw(src, i)));
  endtask

  vec_t       vecs[$];
  stim_t      prev;
  stim_t      cur;
  rbus_ctrl_t c0;
  rbus_ctrl_t c5;
  rbus_ctrl_t c6;
  rbus_word_t zero_w;
  rbus_word_t one_w;

  initial begin
    c0       = '0;
    c5       = ctl(1'b0, 3'd5, 4'h2);
    c6       = ctl(1'b1, 3'd6, 4'h3);
    zero_w   = '0;
    one_w.raw = 64'h1;

    rst = 1'b1;
    step(ring(1'b0, c0, zero_w));
    step(ring(1'b0, c0, zero_w));
    check("reset_state", ob(1'b0, c0, zero_w, 1'b1, 1'b0, 1'b0, 8'd0));
    #2 rst = 1'b0;

    // Short frame, one row per clock: inputs, then outputs expected after the edge.
    vecs.push_back('{dev(1'b1, hdr(1'b0, 1'b0, 8'h11)), ob(1'b0, c0, zero_w, 1'b1, 1'b0, 1'b0, 8'd0)});
    vecs.push_back('{dev(1'b0, one_w),                  ob(1'b0, c0, zero_w, 1'b0, 1'b0, 1'b0, 8'd0)});
    vecs.push_back('{ring(1'b1, c5, hdr(1'b0, 1'b0, 8'h33)),
                     ob(1'b1, ctl(1'b1, 3'd5, 4'h2), hdr(1'b1, 1'b0, 8'h11), 1'b0, 1'b0, 1'b0, 8'd0)});
    vecs.push_back('{ring(1'b0, c6, pw(8'hF2, 0)),      ob(1'b0, c6, one_w, 1'b1, 1'b1, 1'b0, 8'd0)});
    vecs.push_back('{ring(1'b0, c0, pw(8'hF3, 0)),      ob(1'b0, c0, pw(8'hF3, 0), 1'b1, 1'b0, 1'b0, 8'd0)});
    vecs.push_back('{ring(1'b1, c5, hdr(1'b0, 1'b0, 8'h34)),
                     ob(1'b1, c5, hdr(1'b0, 1'b0, 8'h34), 1'b1, 1'b0, 1'b0, 8'd0)});
    vecs.push_back('{dev(1'b0, pw(8'hDE, 0)),           ob(1'b0, c0, zero_w, 1'b1, 1'b0, 1'b0, 8'd0)});
    vecs.push_back('{ring(1'b1, c5, hdr(1'b0, 1'b0, 8'h35)),
                     ob(1'b1, c5, hdr(1'b0, 1'b0, 8'h35), 1'b1, 1'b0, 1'b0, 8'd0)});
    foreach (vecs[i]) begin
      step(vecs[i].in);
      check($sformatf("short_vec%0d", i), vecs[i].exp);
    end

    // Pass-through with nothing loaded.
    prev = '0;
    for (int i = 0; i < 40; i++) begin
      cur        = '0;
      cur.r_sof  = 1'($urandom);
      cur.r_ctrl = rbus_ctrl_t'($urandom);
      cur.r_bus  = rbus_word_t'({$urandom, $urandom});
      step(cur);
      check($sformatf("pass_%0d", i), ob(cur.r_sof, cur.r_ctrl, cur.r_bus, 1'b1, 1'b0, 1'b0, 8'd0));
      prev = cur;
    end

    // Long frame: four unusable slots, then injection into the fifth.
    load_long(8'h20);
    check("long_loaded", ob(1'b0, c0, zero_w, 1'b0, 1'b0, 1'b0, 8'd0));
    for (int k = 0; k < 4; k++) begin
      cur = ring(1'b1, c0, (k < 3) ? hdr(1'b1, 1'b1, 8'(k)) : hdr(1'b0, 1'b0, 8'h44));
      step(cur);
      check($sformatf("long_skip%0d", k), ob(1'b1, c0, cur.r_bus, 1'b0, 1'b0, 1'b0, 8'(k + 1)));
      step(ring(1'b0, c0, pw(8'hF0, k)));
    end
    step(ring(1'b1, ctl(1'b0, 3'd1, 4'h1), hdr(1'b0, 1'b1, 8'h55)));
    check("long_hdr", ob(1'b1, ctl(1'b1, 3'd1, 4'h1), hdr(1'b1, 1'b1, 8'h20), 1'b0, 1'b0, 1'b0, 8'd0));
    for (int i = 1; i <= 8; i++) begin
      step(ring(1'b0, ctl(1'b0, 3'd2, 4'(i)), pw(8'hEE, 0)));
      check($sformatf("long_pay%0d", i),
            ob(1'b0, ctl(1'b0, 3'd2, 4'(i)), pw(8'h20, i), 1'(i == 8), 1'(i == 8), 1'b0, 8'd0));
    end
    step(ring(1'b0, c0, pw(8'hF9, 0)));
    check("long_after", ob(1'b0, c0, pw(8'hF9, 0), 1'b1, 1'b0, 1'b0, 8'd0));

    // Early sof during SEND: once into a non-match, once into a match.
    load_long(8'h30);
    step(ring(1'b1, c0, hdr(1'b0, 1'b1, 8'h66)));
    check("early_hdr1", ob(1'b1, ctl(1'b1, 3'd0, 4'h0), hdr(1'b1, 1'b1, 8'h30), 1'b0, 1'b0, 1'b0, 8'd0));
    for (int i = 1; i <= 3; i++) begin
      step(ring(1'b0, c0, zero_w));
      check($sformatf("early_pay%0d", i), ob(1'b0, c0, pw(8'h30, i), 1'b0, 1'b0, 1'b0, 8'd0));
    end
    step(ring(1'b1, c0, hdr(1'b1, 1'b1, 8'h77)));
    check("early_abort_nomatch", ob(1'b1, c0, hdr(1'b1, 1'b1, 8'h77), 1'b0, 1'b0, 1'b1, 8'd1));
    step(ring(1'b0, c0, pw(8'hF5, 0)));
    check("early_passed", ob(1'b0, c0, pw(8'hF5, 0), 1'b0, 1'b0, 1'b0, 8'd1));
    step(ring(1'b1, c0, hdr(1'b0, 1'b1, 8'h67)));
    check("early_hdr2", ob(1'b1, ctl(1'b1, 3'd0, 4'h0), hdr(1'b1, 1'b1, 8'h30), 1'b0, 1'b0, 1'b0, 8'd0));
    step(ring(1'b0, c0, zero_w));
    step(ring(1'b0, c0, zero_w));
    step(ring(1'b1, c5, hdr(1'b0, 1'b1, 8'h68)));
    check("early_abort_match",
          ob(1'b1, ctl(1'b1, 3'd5, 4'h2), hdr(1'b1, 1'b1, 8'h30), 1'b0, 1'b0, 1'b1, 8'd0));
    for (int i = 1; i <= 8; i++) begin
      step(ring(1'b0, c0, zero_w));
      check($sformatf("early_full%0d", i), ob(1'b0, c0, pw(8'h30, i), 1'(i == 8), 1'(i == 8), 1'b0, 8'd0));
    end

    // Device restart: only the second (short) frame is injected.
    step(dev(1'b1, hdr(1'b0, 1'b1, 8'h40)));
    for (int i = 1; i <= 3; i++)
      step(dev(1'b0, pw(8'h40, i)));
    step(dev(1'b1, hdr(1'b0, 1'b0, 8'h41)));
    check("restart_hdr", ob(1'b0, c0, zero_w, 1'b1, 1'b0, 1'b0, 8'd0));
    step(dev(1'b0, pw(8'hBE, 0)));
    check("restart_loaded", ob(1'b0, c0, zero_w, 1'b0, 1'b0, 1'b0, 8'd0));
    step(ring(1'b1, c0, hdr(1'b0, 1'b1, 8'h88)));
    check("restart_len_skip", ob(1'b1, c0, hdr(1'b0, 1'b1, 8'h88), 1'b0, 1'b0, 1'b0, 8'd1));
    step(ring(1'b1, c0, hdr(1'b0, 1'b0, 8'h89)));
    check("restart_inj_hdr", ob(1'b1, ctl(1'b1, 3'd0, 4'h0), hdr(1'b1, 1'b0, 8'h41), 1'b0, 1'b0, 1'b0, 8'd0));
    step(ring(1'b0, c0, zero_w));
    check("restart_inj_pay", ob(1'b0, c0, pw(8'hBE, 0), 1'b1, 1'b1, 1'b0, 8'd0));

    // starve_cnt saturates at 255 and clears on injection.
    step(dev(1'b1, hdr(1'b0, 1'b0, 8'h50)));
    step(dev(1'b0, pw(8'h05, 0)));
    for (int i = 0; i < 260; i++)
      step(ring(1'b1, c0, hdr(1'b1, 1'b0, 8'h00)));
    check("starve_sat", ob(1'b1, c0, hdr(1'b1, 1'b0, 8'h00), 1'b0, 1'b0, 1'b0, 8'd255));
    step(ring(1'b1, c0, hdr(1'b0, 1'b0, 8'h51)));
    check("starve_clear", ob(1'b1, ctl(1'b1, 3'd0, 4'h0), hdr(1'b1, 1'b0, 8'h50), 1'b0, 1'b0, 1'b0, 8'd0));
    step(ring(1'b0, c0, zero_w));
    check("starve_pay", ob(1'b0, c0, pw(8'h05, 0), 1'b1, 1'b1, 1'b0, 8'd0));

    // Reset asserted mid-SEND.
    load_long(8'h60);
    step(ring(1'b1, c0, hdr(1'b0, 1'b1, 8'h61)));
    step(ring(1'b0, c5, zero_w));
    step(ring(1'b0, c5, zero_w));
    check("rst_pre", ob(1'b0, c5, pw(8'h60, 2), 1'b0, 1'b0, 1'b0, 8'd0));
    rst = 1'b1;
    #1;
    check("rst_mid_send", ob(1'b0, c0, zero_w, 1'b1, 1'b0, 1'b0, 8'd0));
    #2 rst = 1'b0;
    step(ring(1'b1, c5, hdr(1'b0, 1'b1, 8'h99)));
    check("rst_after_sof", ob(1'b1, c5, hdr(1'b0, 1'b1, 8'h99), 1'b1, 1'b0, 1'b0, 8'd0));
    step(ring(1'b0, c0, pw(8'h77, 0)));
    check("rst_after_word", ob(1'b0, c0, pw(8'h77, 0), 1'b1, 1'b0, 1'b0, 8'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rsbus_d2r_inject.md
# rsbus_d2r_inject

Device-side inserter for the d2r ring, sitting directly upstream of the packet-interception stage on the same ring. A device loads one complete request frame (header plus 1 or 8 payload words) into a local buffer. The block waits for an empty ring slot of matching length and overwrites that slot with the buffered frame. Every other slot passes through with one register stage of latency.

## Interface
- No parameters.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- d2r_i_sof  in  1  slot start, marks the header word
- d2r_i_ctrl  in  rbus_ctrl_t  ring control word
- d2r_i_bus  in  rbus_word_t  ring data word
- d2r_o_sof  out  1  registered slot start
- d2r_o_ctrl  out  rbus_ctrl_t  registered control word
- d2r_o_bus  out  rbus_word_t  registered data word
- dev_i_stb  in  1  device word valid
- dev_i_sof  in  1  with dev_i_stb, the word is a frame header
- dev_i_bus  in  rbus_word_t  device word
- dev_o_rdy  out  1  buffer accepts words
- pkt_sent  out  1  one-cycle pulse when the last injected word leaves on d2r_o_bus
- inj_err  out  1  one-cycle pulse when a send is aborted
- starve_cnt  out  8  saturating count of ring slots skipped while ARMED

## Operation
- Buffer: 9 words of rbus_word_t.
  - Index 0 holds the header.
  - Payload count N = 1 when the header's frm_len = 0; N = 8 when frm_len = 1.
- States:
  - IDLE
    - dev_i_stb && dev_i_sof: write the header to index 0, set wr_idx = 1, go to LOAD.
    - dev_i_stb without dev_i_sof: word ignored.
  - LOAD
    - dev_i_stb && !dev_i_sof: write the word to wr_idx, then wr_idx++.
    - After payload word N is written, go to ARMED.
    - dev_i_stb && dev_i_sof: discard the partial frame, write the new header to index 0, set wr_idx = 1, stay in LOAD.
  - ARMED
    - dev_o_rdy = 0.
    - On d2r_i_sof, the slot is a match when d2r_i_bus.header.frm_used == 0 and d2r_i_bus.header.frm_len == buffered frm_len.
    - Match: output the buffered header with frm_used forced to 1, set rd_idx = 1, go to SEND, clear starve_cnt.
    - No match: the slot passes through and starve_cnt increments, saturating at 255.
  - SEND
    - Each non-sof cycle: output buffer[rd_idx], then rd_idx++.
    - After word N: pkt_sent pulses, go to IDLE.
    - d2r_i_sof arriving before N words are sent (malformed ring): abort. inj_err pulses, go to ARMED, and evaluate that same sof as a fresh match candidate in the same cycle.
- Control word handling:
  - Injected header cycle: d2r_o_ctrl.valid = 1; all other control bits are copied from d2r_i_ctrl.
  - Injected payload cycles and all pass-through cycles: d2r_o_ctrl = d2r_i_ctrl.
- Slot words after word N and before the next sof pass through unchanged.
- dev_o_rdy = 1 in IDLE and LOAD only.

## Timing
- Every d2r output is registered, with exactly 1 cycle of latency from input to output, whether passing through or injecting.
- State, indices, dev_o_rdy, pkt_sent, inj_err and starve_cnt are all registered.
- Reset values:
  - d2r_o_sof, d2r_o_ctrl, d2r_o_bus: 0.
  - pkt_sent, inj_err, starve_cnt: 0.
  - dev_o_rdy: 1.
  - State: IDLE.
- dev_o_rdy deasserts in the cycle after the last payload write. The device must drop dev_i_stb on sampling dev_o_rdy = 0.
- The header match decision uses only the current-cycle d2r_i_sof and d2r_i_bus; there is no lookahead.
- pkt_sent is asserted in the same cycle that d2r_o_bus carries payload word N.
- Reset asserted during SEND: outputs clear immediately, the buffered frame is lost, and the state returns to IDLE.

## Structure
- The following belong in rbus_pkg, not locally:
  - payload length constants PAYLOAD_SHORT = 1 and PAYLOAD_LONG = 8;
  - a function returning N from frm_len.
- Uses the existing rbus_ctrl_t, rbus_word_t and header field definitions.
- One natural sub-module, rsbus_frm_buf: the 9-word buffer with write index, read index and full flag.
- The FSM and the ring output mux stay in the top module.

## Test plan
- Short frame: device loads a header with frm_len = 0 plus payload 64'h1. The next slot is empty with frm_len = 0. Required: d2r_o_bus shows the header with frm_used = 1 and ctrl.valid = 1, then payload 1. pkt_sent pulses with the payload word. State returns to IDLE.
- Long frame: device loads 8 payload words. The ring presents 3 occupied slots, then a slot with frm_len = 0, then an empty slot with frm_len = 1. Required: starve_cnt = 4, injection into the fifth slot, all 8 words in order, starve_cnt cleared.
- Pass-through: no frame loaded. Random ring traffic must appear on the outputs bit-exact, delayed by 1 cycle.
- Early sof during SEND (long frame, sof after 3 payload words): inj_err pulses. The next matching empty slot receives the full 9 words.
- Device restart: header, 3 words, then a new header and 1 word with frm_len = 0. Required: only the second frame is injected.
- Reset asserted mid-SEND: all outputs 0 and dev_o_rdy = 1 next cycle; the following ring slot passes through unmodified.
